// File: rtl/micro_sequencer.sv
// micro_sequencer: CAR/SBR next-address sequencer with one-hot micro-op decode,
// memory-handshake stall and HLT freeze.
module micro_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] uinst,
    input  logic [15:0] DR,
    input  logic [15:0] AC,
    input  logic        mem_ready,
    output logic [6:0]  CAR,
    output logic        ADD,
    output logic        CLRAC,
    output logic        INCAC,
    output logic        DRTAC,
    output logic        DRTAR,
    output logic        PCTAR,
    output logic        WRITE,
    output logic        SUB,
    output logic        OR,
    output logic        AND,
    output logic        READ,
    output logic        ACTDR,
    output logic        INCDR,
    output logic        PCTDR,
    output logic        XOR,
    output logic        COM,
    output logic        SHL,
    output logic        SHR,
    output logic        INCPC,
    output logic        ARTPC,
    output logic        halted
);
    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
    state_t st, st_n, mode;
    logic [6:0] sbr, sbr_n, car_n, car_inc, ad;
    logic [2:0] f1, f2, f3;
    logic [1:0] cd, br;
    logic [7:0] s1, s2, s3;
    logic cond, hlt, mem_op, active, go, unused_dr;

    assign {f1, f2, f3, cd, br, ad} = uinst;
    assign unused_dr = ^DR[10:0];
    assign car_inc = CAR + 7'd1;
    assign hlt = f3 == 3'd7;
    assign mem_op = f1 == 3'd7 || f2 == 3'd4;
    assign halted = st == HALT;
    assign active = !rst && !halted;
    assign mode = halted ? HALT : (mem_op && !mem_ready) ? STALL : RUN;
    assign go = mode == RUN;
    assign cond = cd == 2'd0 ? 1'b1 : cd == 2'd1 ? DR[15] : cd == 2'd2 ? AC[15] : AC == 16'd0;
    assign s1 = active ? 8'd1 << f1 : 8'd0;
    assign s2 = active ? 8'd1 << f2 : 8'd0;
    assign s3 = active ? 8'd1 << f3 : 8'd0;

    // During a stall only the memory strobes survive so other transfers fire once
    assign {WRITE, PCTAR, DRTAR, DRTAC, INCAC, CLRAC, ADD} = s1[7:1] & {1'b1, {6{go}}};
    assign {PCTDR, INCDR, ACTDR, READ, AND, OR, SUB} = s2[7:1] & {{3{go}}, 1'b1, {3{go}}};
    assign {ARTPC, INCPC, SHR, SHL, COM, XOR} = s3[6:1] & {6{go}};

    always_comb begin
        car_n = CAR;
        sbr_n = sbr;
        st_n = st;
        if (mode == RUN) begin
            if (hlt) st_n = HALT;
            else begin
                car_n = br[1] ? (br[0] ? {1'b0, DR[14:11], 2'b00} : sbr) : (cond ? ad : car_inc);
                sbr_n = (br == 2'b01 && cond) ? car_inc : sbr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            CAR <= 7'd64;
            sbr <= 7'd0;
            st <= RUN;
        end else begin
            CAR <= car_n;
            sbr <= sbr_n;
            st <= st_n;
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed and random microinstruction streams checked
// against a behavioural sequencer model.
module tb_micro_sequencer;
    logic clk = 1'b0, rst, mem_ready;
    logic [19:0] uinst;
    logic [15:0] DR, AC;
    logic [6:0] CAR;
    logic ADD, CLRAC, INCAC, DRTAC, DRTAR, PCTAR, WRITE;
    logic SUB, OR, AND, READ, ACTDR, INCDR, PCTDR;
    logic XOR, COM, SHL, SHR, INCPC, ARTPC, halted;
    int n = 0, errs = 0;
    int m_car, m_sbr;
    bit m_halt;

    micro_sequencer dut (
        .clk(clk), .rst(rst), .uinst(uinst), .DR(DR), .AC(AC), .mem_ready(mem_ready),
        .CAR(CAR), .ADD(ADD), .CLRAC(CLRAC), .INCAC(INCAC), .DRTAC(DRTAC), .DRTAR(DRTAR),
        .PCTAR(PCTAR), .WRITE(WRITE), .SUB(SUB), .OR(OR), .AND(AND), .READ(READ),
        .ACTDR(ACTDR), .INCDR(INCDR), .PCTDR(PCTDR), .XOR(XOR), .COM(COM), .SHL(SHL),
        .SHR(SHR), .INCPC(INCPC), .ARTPC(ARTPC), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(int f1, int f2, int f3, int cd, int br, int ad);
        logic [19:0] u;
        u = {f1[2:0], f2[2:0], f3[2:0], cd[1:0], br[1:0], ad[6:0]};
        return u;
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply(input bit r, input logic [19:0] u, input logic [15:0] d,
                         input logic [15:0] a, input bit mr);
        int f1, f2, f3, cd, br, ad;
        bit c, stall;
        logic [19:0] e, obs;
        f1 = int'(u[19:17]); f2 = int'(u[16:14]); f3 = int'(u[13:11]);
        cd = int'(u[10:9]); br = int'(u[8:7]); ad = int'(u[6:0]);
        rst = r; uinst = u; DR = d; AC = a; mem_ready = mr;
        #1;
        stall = (f1 == 7 || f2 == 4) && !mr;
        c = cd == 0 ? 1'b1 : cd == 1 ? d[15] : cd == 2 ? a[15] : (a == 0);
        e = '0;
        if (!r && !m_halt) begin
            if (f1 != 0) e[f1 - 1] = 1'b1;
            if (f2 != 0) e[7 + f2 - 1] = 1'b1;
            if (f3 != 0 && f3 != 7) e[14 + f3 - 1] = 1'b1;
            if (stall) e = e & 20'h00440;
        end
        obs = {ARTPC, INCPC, SHR, SHL, COM, XOR, PCTDR, INCDR, ACTDR, READ, AND, OR, SUB,
               WRITE, PCTAR, DRTAR, DRTAC, INCAC, CLRAC, ADD};
        chk("car", 20'(CAR), 20'(m_car));
        chk("halted", 20'(halted), 20'(m_halt));
        chk("strobes", obs, e);
        @(posedge clk);
        if (r) begin
            m_car = 64; m_sbr = 0; m_halt = 0;
        end else if (!m_halt && !stall) begin
            if (f3 == 7) m_halt = 1;
            else if (br == 3) m_car = int'(d[14:11]) * 4;
            else if (br == 2) m_car = m_sbr;
            else if (c) begin
                if (br == 1) m_sbr = (m_car + 1) % 128;
                m_car = ad;
            end else m_car = (m_car + 1) % 128;
        end
        #1;
    endtask

    task automatic jmp(input int ad);
        apply(0, mk(0, 0, 0, 0, 0, ad), 16'h0, 16'h1, 1);
    endtask

    initial begin
        rst = 1'b1; uinst = 20'($urandom); DR = '0; AC = '0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        m_car = 64; m_sbr = 0; m_halt = 0;
        apply(1, 20'($urandom), 16'($urandom), 16'($urandom), 0);
        apply(1, 20'($urandom), 16'($urandom), 16'($urandom), 1);
        chk("reset_car", 20'(CAR), 20'd64);
        apply(0, mk(0, 0, 0, 2, 2, 0), 16'h0, 16'h0, 1);
        chk("ret_after_reset", 20'(CAR), 20'd0);
        jmp(5);
        apply(0, mk(0, 0, 0, 0, 1, 70), 16'h0, 16'h0, 1);
        chk("call_car", 20'(CAR), 20'd70);
        apply(0, mk(0, 0, 0, 0, 2, 0), 16'h0, 16'h0, 1);
        chk("ret_car", 20'(CAR), 20'd6);
        apply(0, mk(4, 0, 0, 0, 3, 0), 16'h2800, 16'h0, 1);
        chk("map_car", 20'(CAR), 20'd20);
        jmp(3);
        apply(0, mk(0, 0, 0, 3, 0, 10), 16'h0, 16'h0, 1);
        chk("z_taken", 20'(CAR), 20'd10);
        jmp(3);
        apply(0, mk(0, 0, 0, 3, 0, 10), 16'h0, 16'h0001, 1);
        chk("z_not_taken", 20'(CAR), 20'd4);
        apply(0, mk(0, 0, 0, 2, 0, 50), 16'h0, 16'h8000, 1);
        chk("s_taken", 20'(CAR), 20'd50);
        for (int i = 0; i < 3; i++) apply(0, mk(1, 4, 5, 0, 0, 33), 16'h0, 16'h0, 0);
        apply(0, mk(1, 4, 5, 0, 0, 33), 16'h0, 16'h0, 1);
        chk("stall_release", 20'(CAR), 20'd33);
        apply(0, mk(7, 0, 7, 0, 0, 9), 16'h0, 16'h0, 0);
        apply(0, mk(7, 0, 7, 0, 0, 9), 16'h0, 16'h0, 1);
        chk("hlt_after_stall", 20'(halted), 20'd1);
        apply(1, 20'($urandom), 16'h0, 16'h0, 0);
        jmp(100);
        apply(0, mk(2, 3, 7, 0, 0, 9), 16'h0, 16'h0, 1);
        for (int i = 0; i < 5; i++) apply(0, 20'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        chk("halt_car", 20'(CAR), 20'd100);
        apply(1, 20'($urandom), 16'h0, 16'h0, 1);
        chk("halt_reset", 20'(CAR), 20'd64);
        jmp(127);
        apply(0, mk(0, 0, 0, 1, 0, 9), 16'h0, 16'h0, 1);
        chk("wrap", 20'(CAR), 20'd0);
        jmp(127);
        apply(0, mk(0, 0, 0, 0, 1, 127), 16'h0, 16'h0, 1);
        apply(0, mk(0, 0, 0, 0, 2, 0), 16'h0, 16'h0, 1);
        chk("call_wrap_ret", 20'(CAR), 20'd0);
        for (int i = 0; i < 500; i++) begin
            bit r;
            r = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
            apply(r, 20'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), $urandom_range(0, 2) != 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
